vram_arbiter: RTL and testbench
===============================

# vram_arbiter

- Shares the single-port VDC VRAM among NREQ requesters:
  - requester 0: display fetch (BG/sprite);
  - requester 1: CPU data port;
  - requester 2: DMA (VRAM-VRAM and SATB).
- Display fetch has absolute priority. The remaining requesters are served round-robin.
- Each granted access occupies VRAM for a fixed LAT cycles; read data returns with a per-requester valid pulse.
- Sits between the HuC6270 fetch/CPU/DMA engines and the VRAM port.

## Interface
Parameters:
- NREQ, 3, number of requesters (≥2); index 0 is fixed-priority display fetch
- ADDR_W, 16, VRAM word address width
- DATA_W, 16, VRAM word width
- LAT, 2, cycles VRAM is busy per access (≥1)

Ports:
- Clocking: one clock `clk`; reset is synchronous and active-high.

Clock and reset:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset

Requester side:
- req  in  NREQ  access request per requester, held high until granted
- we  in  NREQ  1 = write, 0 = read; valid with req
- addr  in  NREQ×ADDR_W  word address per requester
- wdata  in  NREQ×DATA_W  write data per requester
- gnt  out  NREQ  one-hot, one-cycle pulse; request accepted this cycle
- rvalid  out  NREQ  one-hot, one-cycle pulse; read data for that requester on rdata
- rdata  out  DATA_W  shared read data, meaningful only with rvalid

VRAM side:
- vram_en  out  1  access active
- vram_we  out  1  write strobe
- vram_addr  out  ADDR_W  address
- vram_wdata  out  DATA_W  write data
- vram_rdata  in  DATA_W  read data, valid at the end of the LAT-th access cycle

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight; down-counter `cnt` runs LAT-1 → 0.
- The arbiter is *free* when in IDLE, or in BUSY with cnt==0.
- When free and any req is high, pick a winner:
  - req[0] wins if high;
  - otherwise the first high req[i] (i ≥ 1) at or after rr_ptr, wrapping from NREQ-1 to 1.
- On a grant:
  - gnt[winner]=1 for that cycle;
  - latch winner's addr/we/wdata and winner index;
  - set cnt=LAT-1; go to (or stay in) BUSY.
- rr_ptr update: when winner ≥ 1, rr_ptr becomes winner+1, wrapping NREQ → 1. A grant to requester 0 leaves rr_ptr unchanged.
- When free and no req is high: return to IDLE.
- vram_en/vram_we/vram_addr/vram_wdata are driven from the latched values for the whole of BUSY. All are 0 in IDLE.
- Read completion:
  - when cnt==0 and the in-flight access is a read, capture vram_rdata into rdata;
  - pulse rvalid[owner] in the following cycle.
- Writes produce no rvalid.
- Requesters must drop or change req in the cycle after gnt. A req still high after gnt is a new request.
- Requester 0 can starve the others; this is by design, because display fetch is hard real-time.
- Reset values: state IDLE, cnt 0, rr_ptr 1, and gnt, rvalid, rdata, vram_en, vram_we, vram_addr, vram_wdata all 0.
- Reset during BUSY abandons the access. No rvalid is emitted afterwards.

## Timing
- Request high in cycle T with arbiter free → gnt in T (combinational from req and state).
- Access occupies cycles T+1 … T+LAT.
- rvalid/rdata appear in cycle T+LAT+1.
- Back-to-back: the next grant may occur in cycle T+LAT, so throughput is one access per LAT cycles with no bubble.
- LAT=1: a grant is possible every cycle; cnt is always 0.
- rvalid for access k and gnt for access k+2 can coincide. rvalid never coincides with another rvalid.

## Structure
- Shared package `vdc_pkg` holds:
  - state enum `vram_arb_state_t` {IDLE, BUSY};
  - constants REQ_DISP=0, REQ_CPU=1, REQ_DMA=2.
- Sub-module `rr_pick`:
  - combinational round-robin picker over req[NREQ-1:1] given rr_ptr;
  - outputs found and index.
- Top level holds the FSM, counter, latches and the fixed-priority override for index 0.

## Test plan
1. Reset, then single CPU read of addr 0x1234 with vram_rdata=0xBEEF at the last access cycle → gnt[1] at T, vram_addr=0x1234 over T+1..T+2, rvalid[1] with rdata=0xBEEF at T+3.
2. CPU and DMA request simultaneously and continuously, no display → grants alternate 1,2,1,2 every 2 cycles; rr_ptr wraps correctly.
3. Display req held continuously alongside CPU req → only gnt[0]. After display drops, CPU is granted at the next free cycle.
4. DMA write of 0x00FF to addr 0x7FFF → vram_we=1 with vram_wdata=0x00FF for 2 cycles; no rvalid.
5. Assert rst at T+1 of a CPU read → all outputs 0 the next cycle, no rvalid, rr_ptr=1; a subsequent DMA request is granted normally.
6. LAT=1 build with three continuous requesters → one grant per cycle, display always first, rvalid exactly one cycle after each read grant's access cycle.

Source files
------------

// File: rtl/vdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdc_pkg
// Description : Shared VDC types and constants. Holds the VRAM arbiter state
//               encoding and the fixed requester slot assignments.
// Revision    : 1.0 - initial release
// ============================================================================
package vdc_pkg;

    // VRAM arbiter state: IDLE = nothing in flight, BUSY = access in flight
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } vram_arb_state_t;

    // Requester slot assignments on the arbiter request vector
    localparam int REQ_DISP = 0;   // display fetch (BG/sprite), fixed priority
    localparam int REQ_CPU  = 1;   // CPU data port
    localparam int REQ_DMA  = 2;   // VRAM-VRAM and SATB DMA

endpackage : vdc_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over requesters 1..NREQ-1.
//               Returns the first asserted request at or after rr_ptr,
//               wrapping from NREQ-1 back to 1 (slot 0 is never considered).
// Ports       : req    [NREQ-1:1] request vector (slot 0 excluded)
//               rr_ptr [IDX_W-1:0] search start, valid range 1..NREQ-1
//               found              at least one request asserted
//               idx    [IDX_W-1:0] winning requester index
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:1]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : p_pick
        int               ptr;
        int               cand;
        logic [IDX_W-1:0] cand_idx;

        found    = 1'b0;
        idx      = '0;
        cand     = 1;
        cand_idx = '0;
        // An out-of-range pointer is treated as 1 so the search stays in 1..NREQ-1.
        ptr = ((rr_ptr == '0) || (int'(rr_ptr) >= NREQ)) ? 1 : int'(rr_ptr);
        for (int k = 0; k < NREQ - 1; k++) begin
            cand     = 1 + ((ptr - 1 + k) % (NREQ - 1));
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares the single-port VDC VRAM among NREQ requesters.
//               Requester 0 (display fetch) has absolute priority; the rest
//               are served round-robin. Each access holds VRAM for LAT cycles
//               and read data returns with a per-requester rvalid pulse.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               req/we/addr/wdata        per-requester access request
//               gnt                      one-hot grant pulse (combinational)
//               rvalid/rdata             one-hot read completion + shared data
//               vram_en/we/addr/wdata    VRAM port, driven for whole access
//               vram_rdata               VRAM read data, valid on last cycle
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vdc_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              we,
    input  logic [NREQ-1:0][ADDR_W-1:0]  addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  wdata,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         vram_en,
    output logic                         vram_we,
    output logic [ADDR_W-1:0]            vram_addr,
    output logic [DATA_W-1:0]            vram_wdata,
    input  logic [DATA_W-1:0]            vram_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    vram_arb_state_t     r_state;
    vram_arb_state_t     w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [NREQ-1:0]     r_rvalid;

    logic                w_free;
    logic                w_last;
    logic                w_pick_found;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_any;
    logic                w_grant;
    logic [IDX_W-1:0]    w_winner;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req[NREQ-1:1]),
        .rr_ptr (r_rr_ptr),
        .found  (w_pick_found),
        .idx    (w_pick_idx)
    );

    // Last cycle of the in-flight access; also the cycle a new grant may land.
    assign w_last   = (r_state == BUSY) && (r_cnt == '0);
    assign w_free   = (r_state == IDLE) || w_last;
    assign w_any    = req[REQ_DISP] | w_pick_found;
    // Reset suppresses grants so nothing is accepted while the arbiter clears.
    assign w_grant  = w_free && w_any && !rst;
    assign w_winner = req[REQ_DISP] ? IDX_W'(REQ_DISP) : w_pick_idx;

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rr_ptr <= IDX_W'(1);
            r_owner  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_next_state;
            r_rvalid <= '0;

            // Read completes on the last access cycle; data is presented next cycle.
            if (w_last && !r_we) begin
                r_rdata           <= vram_rdata;
                r_rvalid[r_owner] <= 1'b1;
            end

            if (w_grant) begin
                r_owner <= w_winner;
                r_we    <= we[w_winner];
                r_addr  <= addr[w_winner];
                r_wdata <= wdata[w_winner];
                r_cnt   <= CNT_W'(LAT - 1);
                // Display grants do not disturb the round-robin order of the rest.
                if (w_winner != '0) begin
                    r_rr_ptr <= (w_winner == IDX_W'(NREQ - 1)) ? IDX_W'(1)
                                                               : w_winner + 1'b1;
                end
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Next-state and grant decode
    always_comb begin
        w_next_state = r_state;
        gnt          = '0;
        if (w_free) begin
            w_next_state = w_any ? BUSY : IDLE;
        end
        if (w_grant) begin
            gnt[w_winner] = 1'b1;
        end
    end

    assign vram_en    = (r_state == BUSY);
    assign vram_we    = (r_state == BUSY) ? r_we    : 1'b0;
    assign vram_addr  = (r_state == BUSY) ? r_addr  : '0;
    assign vram_wdata = (r_state == BUSY) ? r_wdata : '0;
    assign rvalid     = r_rvalid;
    assign rdata      = r_rdata;

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter. One instance
//               at LAT=2 and one at LAT=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // LAT=2 instance
    logic                        rst;
    logic [NREQ-1:0]             req, we;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0][DATA_W-1:0] wdata;
    logic [NREQ-1:0]             gnt, rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        vram_en, vram_we;
    logic [ADDR_W-1:0]           vram_addr;
    logic [DATA_W-1:0]           vram_wdata, vram_rdata;

    // LAT=1 instance
    logic                        rst1;
    logic [NREQ-1:0]             req1, we1;
    logic [NREQ-1:0][ADDR_W-1:0] addr1;
    logic [NREQ-1:0][DATA_W-1:0] wdata1;
    logic [NREQ-1:0]             gnt1, rvalid1;
    logic [DATA_W-1:0]           rdata1;
    logic                        vram_en1, vram_we1;
    logic [ADDR_W-1:0]           vram_addr1;
    logic [DATA_W-1:0]           vram_wdata1, vram_rdata1;

    // VRAM model for the LAT=1 instance: data is a fixed function of address.
    assign vram_rdata1 = vram_addr1 ^ 16'hA5A5;

    vram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    vram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
        .vram_en(vram_en1), .vram_we(vram_we1), .vram_addr(vram_addr1),
        .vram_wdata(vram_wdata1), .vram_rdata(vram_rdata1)
    );

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait to the falling edge (output sample point).
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; vram_rdata = '0;
        req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rst1 = 1'b1;
        clear_inputs();
        step(); step();
        rst = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        req = 3'b111;            // requests during reset must not be granted
        sample();
        tests_run++;
        if ({gnt, rvalid, rdata, vram_en, vram_we, vram_addr, vram_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h en=%b we=%b addr=%h wdata=%h, expected all 0",
                     gnt, rvalid, rdata, vram_en, vram_we, vram_addr, vram_wdata);
        end
        step();
        rst = 1'b0;
        req = '0;
        sample();
        tests_run++;
        if ({gnt, rvalid, vram_en} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: gnt=%b rvalid=%b en=%b, expected 0", gnt, rvalid, vram_en);
        end
        step();
    endtask

    task automatic test_cpu_read();
        do_reset();
        req = 3'b010; addr[1] = 16'h1234; vram_rdata = 16'hBEEF;
        sample();
        tests_run++;
        if (gnt !== 3'b010) begin
            tests_failed++;
            $display("FAIL cpu_read_gnt: gnt=%b expected 010", gnt);
        end
        step();
        req = '0;
        for (int c = 1; c <= 2; c++) begin
            sample();
            tests_run++;
            if (vram_en !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 16'h1234 || rvalid !== 3'b000 || gnt !== 3'b000) begin
                tests_failed++;
                $display("FAIL cpu_read_access%0d: en=%b we=%b addr=%h rvalid=%b gnt=%b expected 1 0 1234 000 000",
                         c, vram_en, vram_we, vram_addr, rvalid, gnt);
            end
            step();
        end
        sample();
        tests_run++;
        if (rvalid !== 3'b010 || rdata !== 16'hBEEF || vram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_read_rvalid: rvalid=%b rdata=%h en=%b expected 010 beef 0", rvalid, rdata, vram_en);
        end
        step();
        sample();
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++;
            $display("FAIL cpu_read_rvalid_pulse: rvalid=%b expected 000", rvalid);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [8];
        exp_g = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        do_reset();
        req = 3'b110; we = 3'b110;
        for (int c = 0; c < 8; c++) begin
            sample();
            tests_run++;
            if (gnt !== exp_g[c]) begin
                tests_failed++;
                $display("FAIL round_robin_c%0d: gnt=%b expected %b", c, gnt, exp_g[c]);
            end
            step();
        end
        req = '0; we = '0;
        step(); step();
    endtask

    task automatic test_display_priority();
        logic [NREQ-1:0] exp_g [7];
        exp_g = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b010};
        do_reset();
        req = 3'b011;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) req = 3'b010;
            sample();
            tests_run++;
            if (gnt !== exp_g[c]) begin
                tests_failed++;
                $display("FAIL display_priority_c%0d: gnt=%b expected %b", c, gnt, exp_g[c]);
            end
            step();
        end
        req = '0;
        step(); step(); step();
    endtask

    task automatic test_dma_write();
        do_reset();
        req = 3'b100; we = 3'b100; addr[2] = 16'h7FFF; wdata[2] = 16'h00FF;
        sample();
        tests_run++;
        if (gnt !== 3'b100) begin
            tests_failed++;
            $display("FAIL dma_write_gnt: gnt=%b expected 100", gnt);
        end
        step();
        req = '0; we = '0;
        for (int c = 1; c <= 3; c++) begin
            sample();
            tests_run++;
            if (c <= 2) begin
                if (vram_en !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 16'h7FFF || vram_wdata !== 16'h00FF || rvalid !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL dma_write_access%0d: en=%b we=%b addr=%h wdata=%h rvalid=%b expected 1 1 7fff 00ff 000",
                             c, vram_en, vram_we, vram_addr, vram_wdata, rvalid);
                end
            end else if (rvalid !== 3'b000 || vram_en !== 1'b0 || vram_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL dma_write_done: rvalid=%b en=%b we=%b expected 000 0 0", rvalid, vram_en, vram_we);
            end
            step();
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        req = 3'b010; addr[1] = 16'h4321; vram_rdata = 16'h5555;
        sample();
        tests_run++;
        if (gnt !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_busy_gnt: gnt=%b expected 010", gnt);
        end
        step();
        req = '0;
        rst = 1'b1;                       // T+1: reset during the access
        step();
        rst = 1'b0;
        sample();                          // T+2
        tests_run++;
        if ({gnt, rvalid, vram_en, vram_we, vram_addr, vram_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_busy_clear: gnt=%b rvalid=%b en=%b addr=%h expected all 0", gnt, rvalid, vram_en, vram_addr);
        end
        step();
        sample();                          // T+3: abandoned read must not complete
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_busy_no_rvalid: rvalid=%b expected 000", rvalid);
        end
        step();
        // Pointer back at 1: CPU beats DMA, then DMA follows.
        req = 3'b110; we = 3'b110;
        sample();
        tests_run++;
        if (gnt !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_busy_rrptr: gnt=%b expected 010", gnt);
        end
        step();
        req = 3'b100;
        step();
        sample();
        tests_run++;
        if (gnt !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_busy_dma: gnt=%b expected 100", gnt);
        end
        step();
        req = '0; we = '0;
        step(); step();
    endtask

    task automatic test_lat1();
        logic [NREQ-1:0] exp_g [8];
        logic [NREQ-1:0] exp_v [8];
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b000, 3'b000};
        exp_v = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
        do_reset();
        addr1[0] = 16'h0100; addr1[1] = 16'h0200; addr1[2] = 16'h0300;
        for (int c = 0; c < 8; c++) begin
            if (c < 3)       req1 = 3'b111;
            else if (c < 6)  req1 = 3'b110;
            else             req1 = 3'b000;
            sample();
            tests_run++;
            if (gnt1 !== exp_g[c] || rvalid1 !== exp_v[c]) begin
                tests_failed++;
                $display("FAIL lat1_c%0d: gnt=%b rvalid=%b expected %b %b", c, gnt1, rvalid1, exp_g[c], exp_v[c]);
            end
            if (exp_v[c] == 3'b010) begin
                tests_run++;
                if (rdata1 !== (16'h0200 ^ 16'hA5A5)) begin
                    tests_failed++;
                    $display("FAIL lat1_rdata_c%0d: rdata=%h expected %h", c, rdata1, 16'h0200 ^ 16'hA5A5);
                end
            end else if (exp_v[c] == 3'b100) begin
                tests_run++;
                if (rdata1 !== (16'h0300 ^ 16'hA5A5)) begin
                    tests_failed++;
                    $display("FAIL lat1_rdata_c%0d: rdata=%h expected %h", c, rdata1, 16'h0300 ^ 16'hA5A5);
                end
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_display_priority();
        test_dma_write();
        test_reset_busy();
        test_lat1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_vram_arbiter
`default_nettype wire
